// File: rtl/frame_detector_core.sv
// rtl/frame_detector_core.sv - framed-stream receiver with speculative FIFO and bit-serial channel replay
//
// Ports:
//   clk_in                    sole clock, rising edge
//   rst_n                     synchronous active-low reset
//   data_in[15:0]             one stream word per edge
//   data_out_ch1..ch8         serial Gray-coded data, MSB first
//   data_vld_ch1..ch8         serial-bit valid per channel
//   fifo_empty                no committed entries pending
//   fifo_full                 committed + speculative entries == FIFO_DEPTH
//   crc_valid / crc_err       one-cycle pulses on good / bad-CRC frame completion

module frame_detector_core #(
  parameter logic [15:0] HEADER_WORD  = 16'hE0E0,
  parameter logic [15:0] TRAILER_WORD = 16'h0E0E,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  output logic        data_out_ch1,
  output logic        data_out_ch2,
  output logic        data_out_ch3,
  output logic        data_out_ch4,
  output logic        data_out_ch5,
  output logic        data_out_ch6,
  output logic        data_out_ch7,
  output logic        data_out_ch8,
  output logic        data_vld_ch1,
  output logic        data_vld_ch2,
  output logic        data_vld_ch3,
  output logic        data_vld_ch4,
  output logic        data_vld_ch5,
  output logic        data_vld_ch6,
  output logic        data_vld_ch7,
  output logic        data_vld_ch8,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        crc_valid,
  output logic        crc_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_H1, S_H2, S_PAYLOAD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;     // payload words received after the channel word
  logic [3:0]  dcnt_q, dcnt_d;   // data words written speculatively
  logic [15:0] w1_q, w1_d;       // previous payload word
  logic [15:0] w2_q, w2_d;       // payload word before that
  logic [15:0] crc_q, crc_d;
  logic [2:0]  ch_q, ch_d;
  logic [AW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic        crc_valid_q, crc_valid_d, crc_err_q, crc_err_d;
  logic [15:0] sh_q, sh_d;
  logic [2:0]  sh_ch_q, sh_ch_d;
  logic [3:0]  bit_q, bit_d;
  logic        act_q, act_d;
  logic [7:0]  dout_q, dout_d, dvld_q, dvld_d;

  logic [18:0] mem_q [FIFO_DEPTH];
  logic        fifo_we;
  logic        empty_w, full_w, pop;
  logic [18:0] rd_entry;
  logic        ch_ok, trailer_done;
  logic [2:0]  ch_idx;

  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ w[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign empty_w  = (cm_q == rd_q);
  assign full_w   = ((wr_q - rd_q) == DEPTH_P);
  assign rd_entry = mem_q[rd_q[AW-1:0]];
  assign ch_ok    = (data_in[15:8] == 8'h00) && $onehot(data_in[7:0]);
  assign trailer_done = (cnt_q != 4'd0) && (w1_q == TRAILER_WORD) && (data_in == TRAILER_WORD);

  always_comb begin
    ch_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (data_in[k]) ch_idx = 3'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    crc_d       = crc_q;
    ch_d        = ch_q;
    wr_d        = wr_q;
    cm_d        = cm_q;
    rd_d        = rd_q;
    crc_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    sh_d        = sh_q;
    sh_ch_d     = sh_ch_q;
    bit_d       = bit_q;
    act_d       = act_q;
    dout_d      = 8'h00;
    dvld_d      = 8'h00;
    fifo_we     = 1'b0;
    pop         = 1'b0;

    // Serializer: the pop happens on the edge that emits bit0 so words run gapless.
    if (act_q) begin
      dout_d[sh_ch_q] = sh_q[15];
      dvld_d[sh_ch_q] = 1'b1;
      sh_d  = {sh_q[14:0], 1'b0};
      bit_d = bit_q + 4'd1;
      if (bit_q == 4'd15) act_d = 1'b0;
    end
    if ((!act_q || bit_q == 4'd15) && !empty_w) begin
      pop     = 1'b1;
      sh_d    = rd_entry[15:0] ^ (rd_entry[15:0] >> 1);
      sh_ch_d = rd_entry[18:16];
      bit_d   = 4'd0;
      act_d   = 1'b1;
      rd_d    = rd_q + PTR_INC;
    end

    case (state_q)
      S_IDLE: if (data_in == HEADER_WORD) state_d = S_H1;
      S_H1:   state_d = (data_in == HEADER_WORD) ? S_H2 : S_IDLE;
      S_H2: begin
        if (data_in != HEADER_WORD) begin
          if (ch_ok) begin
            ch_d    = ch_idx;
            cnt_d   = 4'd0;
            dcnt_d  = 4'd0;
            crc_d   = 16'hFFFF;
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (trailer_done) begin
          // w2 holds the CRC word; everything before it was already written as data.
          state_d = S_IDLE;
          if (dcnt_q == 4'd0) begin
            wr_d = cm_q;
          end else if (crc_q == w2_q) begin
            cm_d        = wr_q;
            crc_valid_d = 1'b1;
          end else begin
            wr_d      = cm_q;
            crc_err_d = 1'b1;
          end
        end else if (cnt_q == 4'd10) begin
          // Eight data words plus CRC already seen and still no trailer.
          wr_d    = cm_q;
          state_d = S_IDLE;
        end else begin
          w2_d  = w1_q;
          w1_d  = data_in;
          cnt_d = cnt_q + 4'd1;
          // The current word plus w1 rule out a trailer, so w2 is confirmed data.
          if (cnt_q >= 4'd2) begin
            if (full_w && !pop) begin
              wr_d    = cm_q;
              state_d = S_IDLE;
            end else begin
              fifo_we = 1'b1;
              wr_d    = wr_q + PTR_INC;
              crc_d   = crc16_word(crc_q, w2_q);
              dcnt_d  = dcnt_q + 4'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      dcnt_q      <= 4'd0;
      w1_q        <= 16'h0000;
      w2_q        <= 16'h0000;
      crc_q       <= 16'hFFFF;
      ch_q        <= 3'd0;
      wr_q        <= '0;
      cm_q        <= '0;
      rd_q        <= '0;
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      sh_q        <= 16'h0000;
      sh_ch_q     <= 3'd0;
      bit_q       <= 4'd0;
      act_q       <= 1'b0;
      dout_q      <= 8'h00;
      dvld_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      crc_q       <= crc_d;
      ch_q        <= ch_d;
      wr_q        <= wr_d;
      cm_q        <= cm_d;
      rd_q        <= rd_d;
      crc_valid_q <= crc_valid_d;
      crc_err_q   <= crc_err_d;
      sh_q        <= sh_d;
      sh_ch_q     <= sh_ch_d;
      bit_q       <= bit_d;
      act_q       <= act_d;
      dout_q      <= dout_d;
      dvld_q      <= dvld_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fifo_we) mem_q[wr_q[AW-1:0]] <= {ch_q, w2_q};
  end

  assign {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
          data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1} = dout_q;
  assign {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
          data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1} = dvld_q;
  assign fifo_empty = empty_w;
  assign fifo_full  = full_w;
  assign crc_valid  = crc_valid_q;
  assign crc_err    = crc_err_q;

endmodule

// File: tb/tb_frame_detector_core.sv
// tb/tb_frame_detector_core.sv - directed self-checking bench for frame_detector_core

module tb_frame_detector_core;

  logic        clk_in;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_out_ch1, data_out_ch2, data_out_ch3, data_out_ch4;
  logic        data_out_ch5, data_out_ch6, data_out_ch7, data_out_ch8;
  logic        data_vld_ch1, data_vld_ch2, data_vld_ch3, data_vld_ch4;
  logic        data_vld_ch5, data_vld_ch6, data_vld_ch7, data_vld_ch8;
  logic        fifo_empty, fifo_full, crc_valid, crc_err;

  frame_detector_core dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in),
    .data_out_ch1(data_out_ch1), .data_out_ch2(data_out_ch2),
    .data_out_ch3(data_out_ch3), .data_out_ch4(data_out_ch4),
    .data_out_ch5(data_out_ch5), .data_out_ch6(data_out_ch6),
    .data_out_ch7(data_out_ch7), .data_out_ch8(data_out_ch8),
    .data_vld_ch1(data_vld_ch1), .data_vld_ch2(data_vld_ch2),
    .data_vld_ch3(data_vld_ch3), .data_vld_ch4(data_vld_ch4),
    .data_vld_ch5(data_vld_ch5), .data_vld_ch6(data_vld_ch6),
    .data_vld_ch7(data_vld_ch7), .data_vld_ch8(data_vld_ch8),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .crc_valid(crc_valid), .crc_err(crc_err)
  );

  logic [7:0] vld_v, dout_v;
  assign vld_v  = {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
                   data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1};
  assign dout_v = {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
                   data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1};

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Observation state, sampled on the falling edge.
  int          cyc = 0;
  int          vld_total, first_vld, last_vld, pv, pe;
  int          vld_ch [8];
  int          nb [8];
  logic [15:0] acc [8];
  logic [18:0] words [$];
  int          multi = 0;
  int          stray = 0;

  always @(negedge clk_in) begin
    int ones;
    cyc++;
    if (crc_valid) pv++;
    if (crc_err) pe++;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      if (vld_v[k]) begin
        ones++;
        vld_ch[k]++;
        acc[k] = {acc[k][14:0], dout_v[k]};
        nb[k]++;
        if (nb[k] == 16) begin
          words.push_back({3'(k), acc[k]});
          nb[k] = 0;
        end
      end else if (dout_v[k]) begin
        stray++;
      end
    end
    if (ones > 1) multi++;
    if (ones > 0) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      vld_total++;
    end
  end

  task automatic clr();
    vld_total = 0; first_vld = -1; last_vld = -1; pv = 0; pe = 0;
    for (int k = 0; k < 8; k++) begin
      vld_ch[k] = 0; nb[k] = 0; acc[k] = 16'h0;
    end
    words.delete();
  endtask

  task automatic send(input logic [15:0] w);
    data_in = w;
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    data_in = 16'h0000;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic frame(input logic [15:0] ch, input logic [15:0] d0, input logic [15:0] crc);
    send(16'hE0E0); send(16'hE0E0); send(ch); send(d0); send(crc);
    send(16'h0E0E); send(16'h0E0E);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_in = 16'h0000;
    clr();
    repeat (10) @(posedge clk_in);
    #1;
    checks++; if (vld_v !== 8'h00) begin errors++; $display("FAIL reset_vld got %h want 00", vld_v); end
    checks++; if (dout_v !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout_v); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    checks++; if ({crc_valid, crc_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {crc_valid, crc_err}); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    clr();
    send(16'hE0E0); send(16'hE0E0); send(16'hE0E0); send(16'h0001);
    send(16'hFFFF); send(16'h0000); send(16'h0E0E); send(16'h0E0E);
    checks++; if (crc_valid !== 1'b1) begin errors++; $display("FAIL single_crc_valid_e1 got %b want 1", crc_valid); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_commit got %b want 0", fifo_empty); end
    checks++; if (data_vld_ch1 !== 1'b0) begin errors++; $display("FAIL single_vld_e1 got %b want 0", data_vld_ch1); end
    idle(1);
    checks++; if (crc_valid !== 1'b0) begin errors++; $display("FAIL single_crc_valid_e2 got %b want 0", crc_valid); end
    checks++; if (data_vld_ch1 !== 1'b0) begin errors++; $display("FAIL single_vld_e2 got %b want 0", data_vld_ch1); end
    idle(1);
    checks++; if ({data_vld_ch1, data_out_ch1} !== 2'b11) begin errors++; $display("FAIL single_first_bit got %b want 11", {data_vld_ch1, data_out_ch1}); end
    idle(30);
    checks++; if (vld_ch[0] !== 16) begin errors++; $display("FAIL single_vld_len got %0d want 16", vld_ch[0]); end
    checks++; if (vld_total !== 16) begin errors++; $display("FAIL single_vld_total got %0d want 16", vld_total); end
    checks++; if (words.size() !== 1) begin errors++; $display("FAIL single_nwords got %0d want 1", words.size()); end
    else begin
      checks++; if (words[0] !== {3'd0, 16'h8000}) begin errors++; $display("FAIL single_word got %h want %h", words[0], {3'd0, 16'h8000}); end
    end
    checks++; if ({pv, pe} !== {32'd1, 32'd0}) begin errors++; $display("FAIL single_pulses got %0d/%0d want 1/0", pv, pe); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_drained got %b want 1", fifo_empty); end
  endtask

  task automatic test_max_length();
    clr();
    send(16'hE0E0); send(16'hE0E0); send(16'h0010); send(16'hFFFF);
    repeat (7) send(16'h0000);
    send(16'h0000); send(16'h0E0E); send(16'h0E0E);
    idle(150);
    checks++; if (vld_ch[4] !== 128) begin errors++; $display("FAIL max_vld_ch5 got %0d want 128", vld_ch[4]); end
    checks++; if (vld_total !== 128) begin errors++; $display("FAIL max_vld_total got %0d want 128", vld_total); end
    checks++; if (last_vld - first_vld + 1 !== 128) begin errors++; $display("FAIL max_continuous got %0d want 128", last_vld - first_vld + 1); end
    checks++; if (pv !== 1) begin errors++; $display("FAIL max_crc_valid got %0d want 1", pv); end
    checks++; if (words.size() !== 8) begin errors++; $display("FAIL max_nwords got %0d want 8", words.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        logic [18:0] exp_w;
        exp_w = (i == 0) ? {3'd4, 16'h8000} : {3'd4, 16'h0000};
        checks++; if (words[i] !== exp_w) begin errors++; $display("FAIL max_word%0d got %h want %h", i, words[i], exp_w); end
      end
    end
  endtask

  task automatic test_crc_error();
    clr();
    frame(16'h0001, 16'h0000, 16'hFFFF);
    checks++; if ({crc_err, crc_valid} !== 2'b10) begin errors++; $display("FAIL crcerr_pulse got %b want 10", {crc_err, crc_valid}); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL crcerr_empty got %b want 1", fifo_empty); end
    idle(30);
    checks++; if (vld_total !== 0) begin errors++; $display("FAIL crcerr_vld got %0d want 0", vld_total); end
    checks++; if ({pv, pe} !== {32'd0, 32'd1}) begin errors++; $display("FAIL crcerr_counts got %0d/%0d want 0/1", pv, pe); end
  endtask

  task automatic test_back_to_back();
    clr();
    frame(16'h0001, 16'hFFFF, 16'h0000);
    frame(16'h0002, 16'h0000, 16'h1D0F);
    idle(60);
    checks++; if (pv !== 2) begin errors++; $display("FAIL b2b_crc_valid got %0d want 2", pv); end
    checks++; if ({vld_ch[0], vld_ch[1]} !== {32'd16, 32'd16}) begin errors++; $display("FAIL b2b_vld got %0d/%0d want 16/16", vld_ch[0], vld_ch[1]); end
    checks++; if (last_vld - first_vld + 1 !== 32) begin errors++; $display("FAIL b2b_gapless got %0d want 32", last_vld - first_vld + 1); end
    checks++; if (words.size() !== 2) begin errors++; $display("FAIL b2b_nwords got %0d want 2", words.size()); end
    else begin
      checks++; if (words[0] !== {3'd0, 16'h8000}) begin errors++; $display("FAIL b2b_word0 got %h want %h", words[0], {3'd0, 16'h8000}); end
      checks++; if (words[1] !== {3'd1, 16'h0000}) begin errors++; $display("FAIL b2b_word1 got %h want %h", words[1], {3'd1, 16'h0000}); end
    end
  endtask

  task automatic test_bad_framing();
    clr();
    // invalid channel word, then stray trailer that must be ignored
    send(16'hE0E0); send(16'hE0E0); send(16'h0003); send(16'h1234);
    send(16'h0E0E); send(16'h0E0E);
    // zero data words before trailer
    send(16'hE0E0); send(16'hE0E0); send(16'h0001); send(16'hFFFF);
    send(16'h0E0E); send(16'h0E0E);
    // twelve words with no trailer, trailer only afterwards
    send(16'hE0E0); send(16'hE0E0); send(16'h0001);
    repeat (12) send(16'h1111);
    send(16'h0E0E); send(16'h0E0E);
    idle(40);
    checks++; if ({pv, pe} !== {32'd0, 32'd0}) begin errors++; $display("FAIL bad_pulses got %0d/%0d want 0/0", pv, pe); end
    checks++; if (vld_total !== 0) begin errors++; $display("FAIL bad_vld got %0d want 0", vld_total); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL bad_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_reset_midstream();
    clr();
    frame(16'h0004, 16'hFFFF, 16'h0000);
    frame(16'h0004, 16'h0000, 16'h1D0F);
    checks++; if (data_vld_ch3 !== 1'b1) begin errors++; $display("FAIL mid_streaming got %b want 1", data_vld_ch3); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL mid_pending got %b want 0", fifo_empty); end
    rst_n = 1'b0;
    data_in = 16'h0000;
    @(posedge clk_in); #1;
    checks++; if ({vld_v, dout_v} !== 16'h0000) begin errors++; $display("FAIL mid_reset_outputs got %h want 0000", {vld_v, dout_v}); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty got %b want 1", fifo_empty); end
    idle(3);
    rst_n = 1'b1;
    clr();
    idle(40);
    checks++; if (vld_total !== 0) begin errors++; $display("FAIL mid_after_reset_vld got %0d want 0", vld_total); end
    // a clean frame on the top channel after recovery
    clr();
    frame(16'h0080, 16'h0000, 16'h1D0F);
    idle(30);
    checks++; if ({pv, vld_ch[7], vld_total} !== {32'd1, 32'd16, 32'd16}) begin errors++; $display("FAIL ch8_frame got %0d/%0d/%0d want 1/16/16", pv, vld_ch[7], vld_total); end
    checks++; if (words.size() !== 1) begin errors++; $display("FAIL ch8_nwords got %0d want 1", words.size()); end
    else begin
      checks++; if (words[0] !== {3'd7, 16'h0000}) begin errors++; $display("FAIL ch8_word got %h want %h", words[0], {3'd7, 16'h0000}); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = 16'h0000;
    clr();
    test_reset();
    test_single();
    test_max_length();
    test_crc_error();
    test_back_to_back();
    test_bad_framing();
    test_reset_midstream();
    checks++; if (multi !== 0) begin errors++; $display("FAIL one_channel_at_a_time got %0d want 0", multi); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL data_without_vld got %0d want 0", stray); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
